// File: rtl/postcode_pkg.sv
// postcode_pkg: command pulse counts, FSM state type and testack helpers.
package postcode_pkg;

  localparam logic [3:0] CMD_OUTPUT = 4'd3;
  localparam logic [3:0] CMD_RESET  = 4'd4;
  localparam logic [3:0] CMD_INPUT  = 4'd12;

  // Pulse number that signals "ready for OUTPUT"; pulses up to PEND_LAST report tx_pending.
  localparam logic [3:0] ACK_READY_PULSE = 4'd3;
  localparam logic [3:0] PEND_LAST       = 4'd4;

  typedef enum logic [0:0] {
    ST_CMD  = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  // Saturating 4-bit increment used for the pulse counter and the pulse index.
  function automatic logic [3:0] next_count(input logic [3:0] c);
    logic [3:0] r;
    if (c == 4'd15) begin
      r = 4'd15;
    end else begin
      r = c + 4'd1;
    end
    return r;
  endfunction

  // testack value for pulse number idx while in CMD: ready flag on pulse 3,
  // tx_pending on the other early pulses, then txin MSB first on pulses 5..12.
  function automatic logic cmd_ack(input logic [3:0] idx, input logic [7:0] tx,
                                   input logic pend);
    logic       a;
    logic [3:0] sel;
    sel = CMD_INPUT - idx;
    if (idx == ACK_READY_PULSE) begin
      a = 1'b1;
    end else if (idx <= PEND_LAST) begin
      a = pend;
    end else if (idx <= CMD_INPUT) begin
      a = pend & tx[sel[2:0]];
    end else begin
      a = 1'b0;
    end
    return a;
  endfunction

endpackage

// File: rtl/postcode_pulse_rx.sv
// postcode_pulse_rx: testreq synchroniser, rising-edge pulse counter and break timer.
module postcode_pulse_rx
  import postcode_pkg::*;
#(
  parameter int BREAK_CYCLES = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       testreq,
  output logic       req_level,
  output logic       pulse,
  output logic [3:0] count,
  output logic       burst_done,
  output logic [3:0] burst_count
);

  localparam int LW = (BREAK_CYCLES > 1) ? $clog2(BREAK_CYCLES) : 1;
  localparam logic [LW-1:0] BREAK_LAST = LW'(BREAK_CYCLES - 1);

  logic          req_meta_r;
  logic          req_sync_r;
  logic          req_prev_r;
  logic [LW-1:0] low_cnt_r;
  logic [3:0]    count_r;
  logic [3:0]    burst_count_r;
  logic          burst_done_r;
  logic          pulse_s;
  logic          break_s;

  assign pulse_s = req_sync_r & ~req_prev_r;
  // low_cnt_r holds the number of earlier low cycles in the run, so this is the
  // BREAK_CYCLES-th consecutive low cycle.
  assign break_s = ~req_sync_r & (low_cnt_r == BREAK_LAST) & (count_r != 4'd0);

  // Synchronise testreq and keep a delayed copy for rising-edge detection
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      req_meta_r <= 1'b0;
      req_sync_r <= 1'b0;
      req_prev_r <= 1'b0;
    end else begin
      req_meta_r <= testreq;
      req_sync_r <= req_meta_r;
      req_prev_r <= req_sync_r;
    end
  end

  // Length of the current low run, parked at the threshold once reached
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      low_cnt_r <= {LW{1'b0}};
    end else if (req_sync_r) begin
      low_cnt_r <= {LW{1'b0}};
    end else if (low_cnt_r != BREAK_LAST) begin
      low_cnt_r <= low_cnt_r + LW'(1);
    end else begin
      low_cnt_r <= low_cnt_r;
    end
  end

  // Saturating pulse count, handed on and cleared when the break is seen
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      count_r       <= 4'd0;
      burst_count_r <= 4'd0;
      burst_done_r  <= 1'b0;
    end else begin
      burst_done_r <= break_s;
      if (break_s) begin
        burst_count_r <= count_r;
        count_r       <= 4'd0;
      end else if (pulse_s) begin
        count_r <= next_count(count_r);
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign req_level   = req_sync_r;
  assign pulse       = pulse_s;
  assign count       = count_r;
  assign burst_done  = burst_done_r;
  assign burst_count = burst_count_r;

endmodule

// File: rtl/postcode.sv
// postcode: POST-box receiver. Decodes testreq bursts into commands and data
// bits, answers on testack and drives a 4-bit HD44780-style LCD port.
module postcode
  import postcode_pkg::*;
#(
  parameter int BREAK_CYCLES = 20,
  parameter int E_CYCLES     = 4
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       testreq,
  output logic       testack,
  output logic [3:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_e,
  input  logic [7:0] txin,
  input  logic       tx_pending
);

  localparam int EW = (E_CYCLES > 1) ? $clog2(E_CYCLES) : 1;
  localparam logic [EW-1:0] E_LAST = EW'(E_CYCLES - 1);

  logic       req_level_s;
  logic       pulse_s;
  logic [3:0] count_s;
  logic       burst_done_s;
  logic [3:0] burst_count_s;

  postcode_pulse_rx #(
    .BREAK_CYCLES(BREAK_CYCLES)
  ) u_pulse_rx (
    .refclk      (refclk),
    .rst         (rst),
    .testreq     (testreq),
    .req_level   (req_level_s),
    .pulse       (pulse_s),
    .count       (count_s),
    .burst_done  (burst_done_s),
    .burst_count (burst_count_s)
  );

  // Only byte[4:0] ever reaches the LCD, so the upper three bits are not kept.
  state_t        state_r, state_next_s;
  logic [2:0]    bit_idx_r, bit_idx_next_s;
  logic [3:0]    shift_r, shift_next_s;
  logic          held_r, held_next_s;
  logic [4:0]    byte_r, byte_next_s;
  logic          testack_r, testack_next_s;
  logic [3:0]    lcd_data_r, lcd_data_next_s;
  logic          lcd_rs_r, lcd_rs_next_s;
  logic          lcd_e_r, lcd_e_next_s;
  logic [EW-1:0] e_cnt_r, e_cnt_next_s;

  logic          bit_ok_s;
  logic [4:0]    assembled_s;
  logic          byte_done_s;
  logic          reset_cmd_s;
  logic          input_cmd_s;
  logic          strobe_s;

  assign bit_ok_s    = (burst_count_s == 4'd1) || (burst_count_s == 4'd2);
  assign assembled_s = {shift_r, (burst_count_s == 4'd2)};
  assign byte_done_s = burst_done_s && (state_r == ST_DATA) && bit_ok_s && (bit_idx_r == 3'd0);
  assign reset_cmd_s = burst_done_s && (state_r == ST_CMD) && (burst_count_s == CMD_RESET);
  assign input_cmd_s = burst_done_s && (state_r == ST_CMD) && (burst_count_s == CMD_INPUT);
  // A repeated INPUT while the strobe is still high restarts it.
  assign strobe_s    = input_cmd_s && (held_r || lcd_e_r);

  // State, data path and registered outputs
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_CMD;
      bit_idx_r  <= 3'd7;
      shift_r    <= 4'd0;
      held_r     <= 1'b0;
      byte_r     <= 5'd0;
      testack_r  <= 1'b0;
      lcd_data_r <= 4'd0;
      lcd_rs_r   <= 1'b0;
      lcd_e_r    <= 1'b0;
      e_cnt_r    <= {EW{1'b0}};
    end else begin
      state_r    <= state_next_s;
      bit_idx_r  <= bit_idx_next_s;
      shift_r    <= shift_next_s;
      held_r     <= held_next_s;
      byte_r     <= byte_next_s;
      testack_r  <= testack_next_s;
      lcd_data_r <= lcd_data_next_s;
      lcd_rs_r   <= lcd_rs_next_s;
      lcd_e_r    <= lcd_e_next_s;
      e_cnt_r    <= e_cnt_next_s;
    end
  end

  // Burst evaluation: command decode in CMD, bit assembly in DATA
  always_comb begin
    state_next_s   = state_r;
    bit_idx_next_s = bit_idx_r;
    shift_next_s   = shift_r;
    held_next_s    = held_r;
    byte_next_s    = byte_r;
    if (burst_done_s) begin
      case (state_r)
        ST_CMD: begin
          case (burst_count_s)
            CMD_RESET: begin
              state_next_s = ST_CMD;
              held_next_s  = 1'b0;
            end
            CMD_OUTPUT: begin
              state_next_s   = ST_DATA;
              bit_idx_next_s = 3'd7;
              shift_next_s   = 4'd0;
            end
            CMD_INPUT: begin
              held_next_s = 1'b0;
            end
            default: begin
              state_next_s = ST_CMD;
            end
          endcase
        end
        ST_DATA: begin
          if (!bit_ok_s) begin
            state_next_s = ST_CMD;
          end else if (bit_idx_r == 3'd0) begin
            state_next_s = ST_CMD;
            held_next_s  = 1'b1;
            byte_next_s  = assembled_s;
            shift_next_s = assembled_s[3:0];
          end else begin
            bit_idx_next_s = bit_idx_r - 3'd1;
            shift_next_s   = assembled_s[3:0];
          end
        end
        default: begin
          state_next_s = ST_CMD;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Next values of testack and the LCD port
  always_comb begin
    testack_next_s  = testack_r;
    lcd_data_next_s = lcd_data_r;
    lcd_rs_next_s   = lcd_rs_r;
    lcd_e_next_s    = lcd_e_r;
    e_cnt_next_s    = e_cnt_r;

    if (reset_cmd_s) begin
      testack_next_s = 1'b0;
    end else if (pulse_s) begin
      if (state_r == ST_DATA) begin
        testack_next_s = 1'b1;
      end else begin
        testack_next_s = cmd_ack(next_count(count_s), txin, tx_pending);
      end
    end else if (!req_level_s) begin
      testack_next_s = 1'b0;
    end else begin
      testack_next_s = testack_r;
    end

    if (strobe_s) begin
      lcd_data_next_s = byte_r[3:0];
      lcd_rs_next_s   = byte_r[4];
    end else if (byte_done_s) begin
      lcd_data_next_s = assembled_s[3:0];
      lcd_rs_next_s   = assembled_s[4];
    end else begin
      lcd_data_next_s = lcd_data_r;
    end

    if (strobe_s) begin
      lcd_e_next_s = 1'b1;
      e_cnt_next_s = E_LAST;
    end else if (e_cnt_r != {EW{1'b0}}) begin
      lcd_e_next_s = 1'b1;
      e_cnt_next_s = e_cnt_r - EW'(1);
    end else begin
      lcd_e_next_s = 1'b0;
      e_cnt_next_s = {EW{1'b0}};
    end
  end

  assign testack  = testack_r;
  assign lcd_data = lcd_data_r;
  assign lcd_rs   = lcd_rs_r;
  assign lcd_e    = lcd_e_r;

endmodule

// File: tb/tb_postcode.sv
// tb_postcode: drives POST bursts on testreq, checks testack per pulse through a
// scoreboard and checks the LCD strobe count, width and data.
`timescale 1ns/1ps
module tb_postcode;

  logic       refclk;
  logic       rst;
  logic       testreq;
  logic       testack;
  logic [3:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_e;
  logic [7:0] txin;
  logic       tx_pending;

  postcode dut (
    .refclk     (refclk),
    .rst        (rst),
    .testreq    (testreq),
    .testack    (testack),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_e      (lcd_e),
    .txin       (txin),
    .tx_pending (tx_pending)
  );

  initial refclk = 1'b0;
  always #250 refclk = ~refclk;

  typedef struct {
    int   due;
    logic exp;
    logic care;
    int   tag;
  } sb_t;

  typedef struct {
    logic [7:0]  txin;
    logic        pend;
    logic [11:0] exp;
    logic [11:0] care;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[5];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   burst_no = 0;
  int   e_rises = 0;
  int   e_cur = 0;
  int   e_width = 0;
  logic e_prev = 1'b0;
  int   rises0;

  always @(posedge refclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: testack is valid 3 cycles after the pulse is driven
  always @(negedge refclk) begin : sb_mon
    sb_t e;
    if (sb_q.size() > 0) begin
      if (sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        if (e.care) check($sformatf("testack burst/pulse %0d", e.tag), {31'd0, testack}, {31'd0, e.exp});
      end
    end
  end

  // LCD strobe monitor: rising edges and high width
  always @(negedge refclk) begin
    if (lcd_e && !e_prev) e_rises++;
    if (lcd_e) e_cur++;
    else if (e_prev) begin
      e_width = e_cur;
      e_cur   = 0;
    end
    e_prev = lcd_e;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic gap(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic pulse(input logic exp, input logic care, input int tag);
    sb_t e;
    e.due  = cyc + 3;
    e.exp  = exp;
    e.care = care;
    e.tag  = tag;
    sb_q.push_back(e);
    testreq = 1'b1;
    @(negedge refclk);
    testreq = 1'b0;
    @(negedge refclk);
  endtask

  // Pulse i (1-based) of an n-pulse burst expects exp[n-i]
  task automatic burst(input int n, input logic [15:0] exp, input logic [15:0] care,
                       input int split_at, input int split_len);
    burst_no++;
    for (int i = 1; i <= n; i++) begin
      pulse(exp[n-i], care[n-i], burst_no * 100 + i);
      if (i == split_at) gap(split_len);
    end
    gap(50);
  endtask

  task automatic cmd(input int n, input logic [15:0] exp);
    burst(n, exp, 16'hFFFF, 0, 0);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      if (b[i]) cmd(2, 16'b11);
      else cmd(1, 16'b1);
    end
  endtask

  initial begin
    vecs[0] = '{txin: 8'hA5, pend: 1'b1, exp: 12'b1110_1010_0101, care: 12'b1110_1111_1111};
    vecs[1] = '{txin: 8'hA5, pend: 1'b0, exp: 12'b0010_0000_0000, care: 12'hFFF};
    vecs[2] = '{txin: 8'h3C, pend: 1'b1, exp: 12'b1110_0011_1100, care: 12'b1110_1111_1111};
    vecs[3] = '{txin: 8'h81, pend: 1'b1, exp: 12'b1110_1000_0001, care: 12'b1110_1111_1111};
    vecs[4] = '{txin: 8'hFF, pend: 1'b0, exp: 12'b0010_0000_0000, care: 12'hFFF};

    rst = 1'b1;
    testreq = 1'b0;
    txin = 8'h00;
    tx_pending = 1'b0;
    repeat (3) @(negedge refclk);
    check("reset testack", {31'd0, testack}, 32'd0);
    check("reset lcd_data", {28'd0, lcd_data}, 32'd0);
    check("reset lcd_rs", {31'd0, lcd_rs}, 32'd0);
    check("reset lcd_e", {31'd0, lcd_e}, 32'd0);
    rst = 1'b0;
    gap(5);

    // RESET then OUTPUT then byte 0x09
    cmd(4, 16'b0010);
    cmd(3, 16'b001);
    send_bits(8'h09, 8);
    check("no strobe during DATA", e_rises, 32'd0);
    check("lcd_data after 0x09", {28'd0, lcd_data}, 32'h9);
    check("lcd_rs after 0x09", {31'd0, lcd_rs}, 32'd0);

    // INPUT with a held byte: one strobe of E_CYCLES
    cmd(12, 16'b0010_0000_0000);
    check("strobe count after INPUT", e_rises, 32'd1);
    check("strobe width", e_width, 32'd4);
    check("lcd_data after INPUT", {28'd0, lcd_data}, 32'h9);
    check("lcd_rs after INPUT", {31'd0, lcd_rs}, 32'd0);

    // INPUT with nothing held
    cmd(12, 16'b0010_0000_0000);
    check("no strobe on second INPUT", e_rises, 32'd1);

    // INPUT answer table
    for (int k = 0; k < 5; k++) begin
      txin = vecs[k].txin;
      tx_pending = vecs[k].pend;
      burst(12, {4'd0, vecs[k].exp}, {4'd0, vecs[k].care}, 0, 0);
    end
    txin = 8'h00;
    tx_pending = 1'b0;
    check("no strobe during INPUT table", e_rises, 32'd1);

    // rst in the middle of a byte
    cmd(3, 16'b001);
    send_bits(8'hF0, 4);
    rst = 1'b1;
    #1;
    check("mid-byte rst lcd_data", {28'd0, lcd_data}, 32'd0);
    check("mid-byte rst lcd_rs", {31'd0, lcd_rs}, 32'd0);
    check("mid-byte rst testack", {31'd0, testack}, 32'd0);
    @(negedge refclk);
    rst = 1'b0;
    gap(5);

    // OUTPUT 0x13 then an INPUT split by a gap shorter than the break
    cmd(3, 16'b001);
    send_bits(8'h13, 8);
    check("lcd_data after 0x13", {28'd0, lcd_data}, 32'h3);
    check("lcd_rs after 0x13", {31'd0, lcd_rs}, 32'd1);
    rises0 = e_rises;
    burst(12, 16'b0010_0000_0000, 16'hFFFF, 6, 15);
    check("strobe after split INPUT", e_rises - rises0, 32'd1);
    check("strobe width 0x13", e_width, 32'd4);
    check("lcd_data on 0x13 strobe", {28'd0, lcd_data}, 32'h3);
    check("lcd_rs on 0x13 strobe", {31'd0, lcd_rs}, 32'd1);

    // Abort inside DATA, then INPUT must not strobe
    cmd(3, 16'b001);
    cmd(3, 16'b111);
    rises0 = e_rises;
    cmd(12, 16'b0010_0000_0000);
    check("no strobe after abort", e_rises - rises0, 32'd0);

    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
